// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register slice: mode encodings
// and the typedef used for the 2-bit operation field.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage : shift_pkg

// File: rtl/shift_word_counter.sv
// Modulo-WIDTH shift counter. Counts increments, can be forced to zero, and
// raises a one-cycle wrap strobe on the edge where it rolls over from WIDTH-1.
module shift_word_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Counter and wrap strobe; clear and zero abort the word without a strobe.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (zero) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule : shift_word_counter

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left and
// parallel load, with a registered serial output and a word-complete counter.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  mode_t            mode_sel;
  logic [WIDTH-1:0] q;
  logic             shift_cyc;
  logic             load_cyc;

  assign mode_sel  = mode_t'(mode);
  assign shift_cyc = en && ((mode_sel == MODE_SHR) || (mode_sel == MODE_SHL));
  assign load_cyc  = en && (mode_sel == MODE_LOAD);
  assign pout      = q;

  // Register and serial output update; so keeps its value on load and hold
  // so freshly loaded data only reaches so on the following shift.
  always_ff @(posedge clk) begin
    if (clear) begin
      q  <= RESET_VAL;
      so <= 1'b0;
    end else if (en) begin
      case (mode_sel)
        MODE_HOLD: ;
        MODE_SHR: begin
          q  <= {si, q[WIDTH-1:1]};
          so <= q[0];
        end
        MODE_SHL: begin
          q  <= {q[WIDTH-2:0], si};
          so <= q[WIDTH-1];
        end
        MODE_LOAD: q <= pin;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (shift_cyc),
    .zero  (load_cyc),
    .cnt   (shift_cnt),
    .wrap  (word_done)
  );

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: an 8-bit instance (RESET_VAL=8'hA5) and a
// 32-bit instance share one stimulus stream and are compared every cycle
// against an arithmetic reference model, plus fixed expected values.
module tb_universal_shift_reg;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        si = 1'b0;
  logic [7:0]  pin8 = '0;
  logic [31:0] pin32 = '0;

  logic [7:0]  pout8;
  logic        so8;
  logic [2:0]  cnt8;
  logic        wd8;
  logic [31:0] pout32;
  logic        so32;
  logic [4:0]  cnt32;
  logic        wd32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .si(si), .pin(pin8),
    .pout(pout8), .so(so8), .shift_cnt(cnt8), .word_done(wd8)
  );

  universal_shift_reg #(.WIDTH(32)) dut32 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .si(si), .pin(pin32),
    .pout(pout32), .so(so32), .shift_cnt(cnt32), .word_done(wd32)
  );

  // Reference model: register as an integer, shifts counted since last
  // load/clear; the counter is that count modulo the width.
  int          mw [2] = '{8, 32};
  logic [63:0] mrv[2] = '{64'hA5, 64'h0};
  logic [63:0] mq [2];
  logic        mso[2];
  int          mn [2];
  logic        mwd[2];

  task automatic model_edge();
    logic [63:0] mask;
    logic [63:0] pv;
    for (int k = 0; k < 2; k++) begin
      mask = (64'd1 << mw[k]) - 64'd1;
      pv   = (k == 0) ? 64'(pin8) : 64'(pin32);
      if (clear) begin
        mq[k] = mrv[k]; mso[k] = 1'b0; mn[k] = 0; mwd[k] = 1'b0;
      end else if (!en || mode == 2'd0) begin
        mwd[k] = 1'b0;
      end else if (mode == 2'd3) begin
        mq[k] = pv & mask; mn[k] = 0; mwd[k] = 1'b0;
      end else begin
        if (mode == 2'd1) begin
          mso[k] = mq[k][0];
          mq[k]  = (mq[k] >> 1) | (64'(si) << (mw[k] - 1));
        end else begin
          mso[k] = mq[k][mw[k] - 1];
          mq[k]  = ((mq[k] << 1) | 64'(si)) & mask;
        end
        mn[k]  = mn[k] + 1;
        mwd[k] = (mn[k] % mw[k]) == 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, check after it.
  task automatic tick(input logic c, input logic e, input logic [1:0] m,
                      input logic s, input logic [7:0] p8, input logic [31:0] p32);
    @(negedge clk);
    clear = c; en = e; mode = m; si = s; pin8 = p8; pin32 = p32;
    @(posedge clk);
    model_edge();
    #1;
    chk("pout8", 64'(pout8), mq[0]);
    chk("so8",   64'(so8),   64'(mso[0]));
    chk("cnt8",  64'(cnt8),  64'(mn[0] % 8));
    chk("wd8",   64'(wd8),   64'(mwd[0]));
    chk("pout32", 64'(pout32), mq[1]);
    chk("so32",   64'(so32),   64'(mso[1]));
    chk("cnt32",  64'(cnt32),  64'(mn[1] % 32));
    chk("wd32",   64'(wd32),   64'(mwd[1]));
  endtask

  logic [7:0] sipo_bits;
  logic [7:0] piso_exp;
  int         wd_seen;

  initial begin
    // Reset state
    tick(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
    chk("rst_pout8", 64'(pout8), 64'hA5);
    chk("rst_so8", 64'(so8), 64'h0);
    chk("rst_cnt8", 64'(cnt8), 64'h0);
    chk("rst_wd8", 64'(wd8), 64'h0);

    // Clear mid-stream after a few shifts
    tick(1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 32'h0);
    tick(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0);
    tick(1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 32'h0);
    tick(1'b1, 1'b1, 2'd1, 1'b1, 8'h00, 32'h0);
    chk("clr_pout8", 64'(pout8), 64'hA5);
    chk("clr_so8", 64'(so8), 64'h0);
    chk("clr_cnt8", 64'(cnt8), 64'h0);

    // SIPO: 8 right shifts
    sipo_bits = 8'b0100_1101;  // bit i = i-th serial bit
    wd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 2'd1, sipo_bits[i], 8'h00, 32'h0);
      if (wd8) wd_seen++;
      if (i < 7) chk("sipo_wd_early", 64'(wd8), 64'h0);
    end
    chk("sipo_pout", 64'(pout8), 64'h4D);
    chk("sipo_wd", 64'(wd8), 64'h1);
    chk("sipo_cnt", 64'(cnt8), 64'h0);
    tick(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 32'h0);
    chk("sipo_wd_pulse", 64'(wd8), 64'h0);

    // PISO: load C3, 8 left shifts
    tick(1'b0, 1'b1, 2'd3, 1'b0, 8'hC3, 32'hDEADBEEF);
    chk("load_cnt", 64'(cnt8), 64'h0);
    piso_exp = 8'b1100_0011;  // expected so sequence, first value in bit 7
    wd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0);
      chk("piso_so", 64'(so8), 64'(piso_exp[7 - i]));
      if (wd8) wd_seen++;
    end
    tick(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 32'h0);
    if (wd8) wd_seen++;
    chk("piso_wd_count", 64'(wd_seen), 64'd1);

    // SISO latency on the 32-bit instance
    tick(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b1, 2'd1, (i == 1), 8'h00, 32'h0);
      chk("siso_so32", 64'(so32), 64'(i == 33));
    end

    // Enable and hold gaps
    tick(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 32'h0);
      chk("gap_cnt", 64'(cnt8), 64'd4);
      chk("gap_pout", 64'(pout8), 64'hFA);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 32'h0);
      chk("hold_cnt", 64'(cnt8), 64'd4);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0);
    chk("gap_wd", 64'(wd8), 64'h1);

    // Simultaneous clear and load: clear wins
    tick(1'b1, 1'b1, 2'd3, 1'b0, 8'hFF, 32'hFFFFFFFF);
    chk("clr_load_pout", 64'(pout8), 64'hA5);

    // Load on the cycle the counter sits at 7
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 32'h0);
    chk("pre_load_cnt", 64'(cnt8), 64'd7);
    tick(1'b0, 1'b1, 2'd3, 1'b0, 8'h5A, 32'h0);
    chk("load7_cnt", 64'(cnt8), 64'd0);
    chk("load7_wd", 64'(wd8), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_universal_shift_reg
